cpu_controller: RTL and testbench

- Multicycle microcoded-style FSM controller for the group's accumulator/stack CPU datapath.
- Sequences fetch, decode and execute, and drives all bus tri-state enables (T*), register loads (LD*), memory strobes (MM, R_W) and the ALU function select.
- Exposes its current state and next state for debug.
- Decodes the major opcode ir_1, the sub-function ir_2, the ALU op field op, and the condition flag cc.

---
 rtl/cpu_ctrl_pkg.sv | 39 +++
 rtl/cpu_ctrl_next.sv | 51 +++++
 rtl/cpu_controller.sv | 102 ++++++++++
 tb/tb_cpu_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the accumulator/stack CPU controller: state codes,
// major opcodes, stack sub-functions and the ALU function codes it issues.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH0   = 4'd0,
        FETCH1   = 4'd1,
        FETCH2   = 4'd2,
        DECODE   = 4'd3,
        ALU_A    = 4'd4,
        ALU_B    = 4'd5,
        BRANCH   = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        WB       = 4'd9,
        ST_DATA  = 4'd10,
        MEM_WR   = 4'd11,
        SP_ADDR  = 4'd12,
        SP_UPD   = 4'd13,
        STK_RD   = 4'd14,
        PC_SAVE  = 4'd15
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ALU = 4'b0001;
    localparam logic [3:0] OP_BR  = 4'b0011;
    localparam logic [3:0] OP_MEM = 4'b1010;
    localparam logic [3:0] OP_STK = 4'b1111;

    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] CALL = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    localparam logic [2:0] FN_NONE = 3'b000;
    localparam logic [2:0] FN_INC  = 3'b110;
    localparam logic [2:0] FN_DEC  = 3'b111;

endpackage

// File: rtl/cpu_ctrl_next.sv
// Pure combinational next-state function of the controller FSM.
module cpu_ctrl_next
    import cpu_ctrl_pkg::*;
(
    input  state_t     cur,
    input  logic [3:0] ir_1,
    input  logic [1:0] ir_2,
    input  logic       cc,
    output state_t     nxt
);

    always_comb begin
        nxt = FETCH0;
        case (cur)
            FETCH0: nxt = FETCH1;
            FETCH1: nxt = FETCH2;
            FETCH2: nxt = DECODE;
            DECODE: begin
                case (ir_1)
                    OP_ALU:  nxt = ALU_A;
                    OP_BR:   nxt = cc ? BRANCH : FETCH0;
                    OP_MEM:  nxt = MEM_ADDR;
                    // PUSH/CALL pre-decrement SP; POP/RET address via SP first
                    OP_STK:  nxt = ir_2[0] ? SP_ADDR : SP_UPD;
                    default: nxt = FETCH0;
                endcase
            end
            ALU_A:    nxt = ALU_B;
            ALU_B:    nxt = FETCH0;
            BRANCH:   nxt = FETCH0;
            MEM_ADDR: nxt = ir_2[0] ? ST_DATA : MEM_RD;
            MEM_RD:   nxt = WB;
            WB:       nxt = (ir_1 == OP_STK) ? SP_UPD : FETCH0;
            ST_DATA:  nxt = MEM_WR;
            // CALL finishes by jumping to the label once the return PC is stored
            MEM_WR:   nxt = (ir_1 == OP_STK && ir_2 == CALL) ? BRANCH : FETCH0;
            SP_ADDR: begin
                case (ir_2)
                    PUSH:    nxt = ST_DATA;
                    CALL:    nxt = PC_SAVE;
                    default: nxt = STK_RD;
                endcase
            end
            SP_UPD:   nxt = ir_2[0] ? FETCH0 : SP_ADDR;
            STK_RD:   nxt = WB;
            PC_SAVE:  nxt = MEM_WR;
            default:  nxt = FETCH0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle controller for the accumulator/stack CPU: state register plus
// combinational decode of bus enables, register loads, memory strobes and ALU op.
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op,
    input  logic       cc,
    input  logic [3:0] ir_1,
    input  logic [1:0] ir_2,
    output logic [3:0] state,
    output logic [3:0] nextstate,
    output logic       TMDR,
    output logic       Tlabel,
    output logic       Tpc,
    output logic       Tsp,
    output logic       Treg,
    output logic       LDmar,
    output logic       LDmdr,
    output logic       LDy,
    output logic       LDir,
    output logic       LDsp,
    output logic       LDpc,
    output logic       LDreg,
    output logic       R_W,
    output logic       MM,
    output logic       ALUon,
    output logic [2:0] fnSelect
);

    state_t cur;
    state_t nxt;
    logic   unused_op3;

    assign unused_op3 = op[3];
    assign state      = cur;
    assign nextstate  = nxt;

    cpu_ctrl_next u_next (
        .cur  (cur),
        .ir_1 (ir_1),
        .ir_2 (ir_2),
        .cc   (cc),
        .nxt  (nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= FETCH0;
        else      cur <= nxt;
    end

    // Outputs are decoded from the live state so an async reset immediately
    // drops any memory strobe and presents the FETCH0 controls.
    always_comb begin
        TMDR     = 1'b0;
        Tlabel   = 1'b0;
        Tpc      = 1'b0;
        Tsp      = 1'b0;
        Treg     = 1'b0;
        LDmar    = 1'b0;
        LDmdr    = 1'b0;
        LDy      = 1'b0;
        LDir     = 1'b0;
        LDsp     = 1'b0;
        LDpc     = 1'b0;
        LDreg    = 1'b0;
        R_W      = 1'b1;
        MM       = 1'b0;
        ALUon    = 1'b0;
        fnSelect = FN_NONE;
        case (cur)
            FETCH0:   begin Tpc = 1'b1; LDmar = 1'b1; end
            FETCH1:   begin MM = 1'b1; LDmdr = 1'b1; end
            FETCH2:   begin TMDR = 1'b1; LDir = 1'b1; LDpc = 1'b1; end
            DECODE:   ;
            ALU_A:    begin Treg = 1'b1; LDy = 1'b1; end
            ALU_B:    begin ALUon = 1'b1; fnSelect = op[2:0]; LDreg = 1'b1; end
            BRANCH:   begin Tlabel = 1'b1; LDpc = 1'b1; end
            MEM_ADDR: begin Tlabel = 1'b1; LDmar = 1'b1; end
            MEM_RD:   begin MM = 1'b1; LDmdr = 1'b1; end
            WB: begin
                TMDR = 1'b1;
                if (ir_1 == OP_STK && ir_2 == RET) LDpc = 1'b1;
                else                               LDreg = 1'b1;
            end
            ST_DATA:  begin Treg = 1'b1; LDmdr = 1'b1; end
            MEM_WR:   begin MM = 1'b1; R_W = 1'b0; end
            SP_ADDR:  begin Tsp = 1'b1; LDmar = 1'b1; end
            SP_UPD: begin
                Tsp      = 1'b1;
                ALUon    = 1'b1;
                LDsp     = 1'b1;
                fnSelect = ir_2[0] ? FN_INC : FN_DEC;
            end
            STK_RD:   begin MM = 1'b1; LDmdr = 1'b1; end
            PC_SAVE:  begin Tpc = 1'b1; LDmdr = 1'b1; end
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class through its
// state sequence and compares state plus the full control vector every cycle.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op;
    logic       cc;
    logic [3:0] ir_1;
    logic [1:0] ir_2;
    logic [3:0] state, nextstate;
    logic TMDR, Tlabel, Tpc, Tsp, Treg;
    logic LDmar, LDmdr, LDy, LDir, LDsp, LDpc, LDreg;
    logic R_W, MM, ALUon;
    logic [2:0] fnSelect;

    int checks = 0;
    int fails  = 0;

    localparam logic [17:0] B_TMDR   = 18'h20000;
    localparam logic [17:0] B_TLABEL = 18'h10000;
    localparam logic [17:0] B_TPC    = 18'h08000;
    localparam logic [17:0] B_TSP    = 18'h04000;
    localparam logic [17:0] B_TREG   = 18'h02000;
    localparam logic [17:0] B_LDMAR  = 18'h01000;
    localparam logic [17:0] B_LDMDR  = 18'h00800;
    localparam logic [17:0] B_LDY    = 18'h00400;
    localparam logic [17:0] B_LDIR   = 18'h00200;
    localparam logic [17:0] B_LDSP   = 18'h00100;
    localparam logic [17:0] B_LDPC   = 18'h00080;
    localparam logic [17:0] B_LDREG  = 18'h00040;
    localparam logic [17:0] B_RW     = 18'h00020;
    localparam logic [17:0] B_MM     = 18'h00010;
    localparam logic [17:0] B_ALUON  = 18'h00008;

    localparam logic [17:0] O_F0     = B_TPC | B_LDMAR | B_RW;
    localparam logic [17:0] O_F1     = B_MM | B_LDMDR | B_RW;
    localparam logic [17:0] O_F2     = B_TMDR | B_LDIR | B_LDPC | B_RW;
    localparam logic [17:0] O_DEC    = B_RW;
    localparam logic [17:0] O_ALUA   = B_TREG | B_LDY | B_RW;
    localparam logic [17:0] O_BR     = B_TLABEL | B_LDPC | B_RW;
    localparam logic [17:0] O_MADDR  = B_TLABEL | B_LDMAR | B_RW;
    localparam logic [17:0] O_MRD    = B_MM | B_LDMDR | B_RW;
    localparam logic [17:0] O_WB_REG = B_TMDR | B_LDREG | B_RW;
    localparam logic [17:0] O_WB_PC  = B_TMDR | B_LDPC | B_RW;
    localparam logic [17:0] O_STD    = B_TREG | B_LDMDR | B_RW;
    localparam logic [17:0] O_MWR    = B_MM;
    localparam logic [17:0] O_SPA    = B_TSP | B_LDMAR | B_RW;
    localparam logic [17:0] O_SPDEC  = B_TSP | B_ALUON | B_LDSP | B_RW | 18'd7;
    localparam logic [17:0] O_SPINC  = B_TSP | B_ALUON | B_LDSP | B_RW | 18'd6;
    localparam logic [17:0] O_SRD    = B_MM | B_LDMDR | B_RW;
    localparam logic [17:0] O_PCS    = B_TPC | B_LDMDR | B_RW;
    localparam logic [17:0] O_ALUB5  = B_ALUON | B_LDREG | B_RW | 18'd5;

    wire [17:0] outs = {TMDR, Tlabel, Tpc, Tsp, Treg, LDmar, LDmdr, LDy, LDir,
                        LDsp, LDpc, LDreg, R_W, MM, ALUon, fnSelect};

    cpu_controller dut (
        .clk(clk), .rst(rst), .op(op), .cc(cc), .ir_1(ir_1), .ir_2(ir_2),
        .state(state), .nextstate(nextstate),
        .TMDR(TMDR), .Tlabel(Tlabel), .Tpc(Tpc), .Tsp(Tsp), .Treg(Treg),
        .LDmar(LDmar), .LDmdr(LDmdr), .LDy(LDy), .LDir(LDir), .LDsp(LDsp),
        .LDpc(LDpc), .LDreg(LDreg), .R_W(R_W), .MM(MM), .ALUon(ALUon),
        .fnSelect(fnSelect)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0]  s[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        logic [17:0] o[4] = '{O_F1, O_F2, O_DEC, O_F0};
        ir_1 = 4'b0000; ir_2 = 2'b00; cc = 1'b0; op = 4'b0000;
        step(); step();
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (nextstate !== 4'd1) begin fails++; $display("FAIL reset_next: got %0d want 1", nextstate); end
        checks++; if (outs !== O_F0) begin fails++; $display("FAIL reset_outs: got %h want %h", outs, O_F0); end
        step();
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL reset_hold: got %0d want 0", state); end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL reset_trace[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL reset_trace_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
    endtask

    task automatic test_push();
        logic [3:0]  s[8] = '{4'd1, 4'd2, 4'd3, 4'd13, 4'd12, 4'd10, 4'd11, 4'd0};
        logic [17:0] o[8] = '{O_F1, O_F2, O_DEC, O_SPDEC, O_SPA, O_STD, O_MWR, O_F0};
        ir_1 = 4'b1111; ir_2 = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL push_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL push_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
    endtask

    task automatic test_pop();
        logic [3:0]  s[8] = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd14, 4'd9, 4'd13, 4'd0};
        logic [17:0] o[8] = '{O_F1, O_F2, O_DEC, O_SPA, O_SRD, O_WB_REG, O_SPINC, O_F0};
        ir_1 = 4'b1111; ir_2 = 2'b01;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL pop_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL pop_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
    endtask

    task automatic test_ret();
        logic [3:0]  s[8] = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd14, 4'd9, 4'd13, 4'd0};
        logic [17:0] o[8] = '{O_F1, O_F2, O_DEC, O_SPA, O_SRD, O_WB_PC, O_SPINC, O_F0};
        ir_1 = 4'b1111; ir_2 = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL ret_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL ret_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
    endtask

    task automatic test_call();
        logic [3:0]  s[9] = '{4'd1, 4'd2, 4'd3, 4'd13, 4'd12, 4'd15, 4'd11, 4'd6, 4'd0};
        logic [17:0] o[9] = '{O_F1, O_F2, O_DEC, O_SPDEC, O_SPA, O_PCS, O_MWR, O_BR, O_F0};
        ir_1 = 4'b1111; ir_2 = 2'b10;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL call_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL call_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
    endtask

    task automatic test_branch();
        logic [3:0]  st[5] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd0};
        logic [17:0] ot[5] = '{O_F1, O_F2, O_DEC, O_BR, O_F0};
        logic [3:0]  sn[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        ir_1 = 4'b0011; ir_2 = 2'b00; cc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (state !== st[i]) begin fails++; $display("FAIL br_taken_state[%0d]: got %0d want %0d", i, state, st[i]); end
            checks++; if (outs !== ot[i]) begin fails++; $display("FAIL br_taken_outs[%0d]: got %h want %h", i, outs, ot[i]); end
        end
        cc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (state !== sn[i]) begin fails++; $display("FAIL br_not_state[%0d]: got %0d want %0d", i, state, sn[i]); end
        end
    endtask

    task automatic test_alu();
        logic [3:0]  s[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        logic [17:0] o[6] = '{O_F1, O_F2, O_DEC, O_ALUA, O_ALUB5, O_F0};
        ir_1 = 4'b0001; ir_2 = 2'b00; op = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL alu_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL alu_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
        op = 4'b0000;
    endtask

    task automatic test_mem_undef();
        logic [3:0]  s[7] = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd0};
        logic [17:0] o[7] = '{O_F1, O_F2, O_DEC, O_MADDR, O_MRD, O_WB_REG, O_F0};
        logic [3:0]  u[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        ir_1 = 4'b1010; ir_2 = 2'b00;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL load_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL load_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
        ir_1 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (state !== u[i]) begin fails++; $display("FAIL undef_state[%0d]: got %0d want %0d", i, state, u[i]); end
        end
    endtask

    // Store aborted by reset while the write strobe is up
    task automatic test_store_abort();
        logic [3:0]  s[6] = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd10, 4'd11};
        logic [17:0] o[6] = '{O_F1, O_F2, O_DEC, O_MADDR, O_STD, O_MWR};
        ir_1 = 4'b1010; ir_2 = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (state !== s[i]) begin fails++; $display("FAIL store_state[%0d]: got %0d want %0d", i, state, s[i]); end
            checks++; if (outs !== o[i]) begin fails++; $display("FAIL store_outs[%0d]: got %h want %h", i, outs, o[i]); end
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin fails++; $display("FAIL abort_state: got %0d want 0", state); end
        checks++; if (MM !== 1'b0 || R_W !== 1'b1) begin fails++; $display("FAIL abort_mem: got MM=%b R_W=%b want MM=0 R_W=1", MM, R_W); end
        checks++; if (outs !== O_F0) begin fails++; $display("FAIL abort_outs: got %h want %h", outs, O_F0); end
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; op = 4'b0000; cc = 1'b0; ir_1 = 4'b0000; ir_2 = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        test_reset();
        test_push();
        test_pop();
        test_ret();
        test_call();
        test_branch();
        test_alu();
        test_mem_undef();
        test_store_abort();
        test_push();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
